// File: rtl/column_hamm_decode_pkg.sv
// Shared definitions for the column Hamming code: widths, syndrome constants,
// decoded-word record and the parity function used by both encoder and decoder.
package column_hamm_decode_pkg;

    localparam int WORD_W = 10;
    localparam int ADDR_W = 6;
    localparam int SYN_W  = 4;

    // Syndrome produced by a single flipped bit at each position.
    localparam logic [SYN_W-1:0] SYN_CLEAN = 4'b0000;
    localparam logic [SYN_W-1:0] SYN_D0    = 4'b0011;
    localparam logic [SYN_W-1:0] SYN_D1    = 4'b0101;
    localparam logic [SYN_W-1:0] SYN_D2    = 4'b0110;
    localparam logic [SYN_W-1:0] SYN_D3    = 4'b0111;
    localparam logic [SYN_W-1:0] SYN_D4    = 4'b1001;
    localparam logic [SYN_W-1:0] SYN_D5    = 4'b1010;
    localparam logic [SYN_W-1:0] SYN_P0    = 4'b0001;
    localparam logic [SYN_W-1:0] SYN_P1    = 4'b0010;
    localparam logic [SYN_W-1:0] SYN_P2    = 4'b0100;
    localparam logic [SYN_W-1:0] SYN_P3    = 4'b1000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              corr;
        logic              uncorr;
        logic              oor;
    } col_out_t;

    function automatic logic [SYN_W-1:0] col_parity(input logic [ADDR_W-1:0] d);
        return {d[4] ^ d[5],
                d[1] ^ d[2] ^ d[3],
                d[0] ^ d[2] ^ d[3] ^ d[5],
                d[0] ^ d[1] ^ d[3] ^ d[4]};
    endfunction

endpackage

// File: rtl/column_hamm_syndrome.sv
// Combinational syndrome logic: the first half computes S for an incoming word,
// the second half maps a (registered) syndrome to a data-correction mask and flags.
module column_hamm_syndrome
    import column_hamm_decode_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [SYN_W-1:0]  syn_o,
    input  logic [SYN_W-1:0]  dec_syn_i,
    output logic [ADDR_W-1:0] mask_o,
    output logic              corr_o,
    output logic              uncorr_o
);

    assign syn_o = col_parity(word_i[ADDR_W-1:0]) ^ word_i[WORD_W-1:ADDR_W];

    always_comb begin
        // NOTE: every output gets a default before the case so no branch can infer a latch.
        mask_o   = '0;
        corr_o   = 1'b0;
        uncorr_o = 1'b0;
        case (dec_syn_i)
            SYN_CLEAN: ;
            SYN_D0: begin mask_o = 6'b000001; corr_o = 1'b1; end
            SYN_D1: begin mask_o = 6'b000010; corr_o = 1'b1; end
            SYN_D2: begin mask_o = 6'b000100; corr_o = 1'b1; end
            SYN_D3: begin mask_o = 6'b001000; corr_o = 1'b1; end
            SYN_D4: begin mask_o = 6'b010000; corr_o = 1'b1; end
            SYN_D5: begin mask_o = 6'b100000; corr_o = 1'b1; end
            SYN_P0, SYN_P1, SYN_P2, SYN_P3: corr_o = 1'b1;
            default: uncorr_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/column_hamm_decode.sv
// Two-stage elastic Hamming decoder for 10-bit column words, with saturating
// corrected/uncorrectable statistics counted on delivered words.
module column_hamm_decode
    import column_hamm_decode_pkg::*;
#(
    parameter int unsigned MAX_COL = 39,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] InWord,
    input  logic              InValid,
    output logic              InReady,
    output logic [ADDR_W-1:0] OutAddr,
    output logic              OutCorr,
    output logic              OutUncorr,
    output logic              OutRange,
    output logic              OutValid,
    input  logic              OutReady,
    input  logic              CntClear,
    output logic [CNT_W-1:0]  CorrCnt,
    output logic [CNT_W-1:0]  UncorrCnt
);

    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_data_q;
    logic [SYN_W-1:0]  s1_syn_q;
    logic [SYN_W-1:0]  in_syn;
    logic              out_valid_q;
    col_out_t          out_q;
    col_out_t          dec_d;
    logic [ADDR_W-1:0] mask;
    logic              dec_corr;
    logic              dec_uncorr;
    logic              s1_adv;
    logic              s2_adv;
    logic              out_hs;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    column_hamm_syndrome u_syndrome (
        .word_i    (InWord),
        .syn_o     (in_syn),
        .dec_syn_i (s1_syn_q),
        .mask_o    (mask),
        .corr_o    (dec_corr),
        .uncorr_o  (dec_uncorr)
    );

    // Ready depends only on pipeline state, never on InValid.
    assign s2_adv  = !out_valid_q || OutReady;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign InReady = s1_adv;
    assign out_hs  = out_valid_q && OutReady;

    always_comb begin
        dec_d.addr   = s1_data_q ^ mask;
        dec_d.corr   = dec_corr;
        dec_d.uncorr = dec_uncorr;
        dec_d.oor    = 32'(dec_d.addr) > MAX_COL;
    end

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (CntClear) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (out_q.corr && corr_cnt_q != '1)
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            if (out_q.uncorr && uncorr_cnt_q != '1)
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: datapath registers are reset as well so OutAddr and flags read 0 after reset.
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= InValid;
                if (InValid) begin
                    s1_data_q <= InWord[ADDR_W-1:0];
                    s1_syn_q  <= in_syn;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q)
                    out_q <= dec_d;
            end
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign OutValid  = out_valid_q;
    assign OutAddr   = out_q.addr;
    assign OutCorr   = out_q.corr;
    assign OutUncorr = out_q.uncorr;
    assign OutRange  = out_q.oor;
    assign CorrCnt   = corr_cnt_q;
    assign UncorrCnt = uncorr_cnt_q;

endmodule

// File: tb/tb_column_hamm_decode.sv
// Bench for column_hamm_decode: directed vector table, stall/reset/saturation
// sequences and a randomized run against a brute-force decoding model.
module tb_column_hamm_decode;

    typedef struct packed {
        logic [5:0] addr;
        logic       corr;
        logic       uncorr;
        logic       oor;
    } exp_t;

    typedef struct packed {
        logic [9:0] word;
        exp_t       exp;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  InWord;
    logic        InValid;
    logic        OutReady;
    logic        CntClear;
    logic        InReady, OutCorr, OutUncorr, OutRange, OutValid;
    logic [5:0]  OutAddr;
    logic [15:0] CorrCnt, UncorrCnt;
    logic        InReady4, OutCorr4, OutUncorr4, OutRange4, OutValid4;
    logic [5:0]  OutAddr4;
    logic [3:0]  CorrCnt4, UncorrCnt4;

    always #5 Clk = ~Clk;

    column_hamm_decode #(.MAX_COL(39), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .InWord(InWord), .InValid(InValid), .InReady(InReady),
        .OutAddr(OutAddr), .OutCorr(OutCorr), .OutUncorr(OutUncorr), .OutRange(OutRange),
        .OutValid(OutValid), .OutReady(OutReady), .CntClear(CntClear),
        .CorrCnt(CorrCnt), .UncorrCnt(UncorrCnt)
    );

    column_hamm_decode #(.MAX_COL(39), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .InWord(InWord), .InValid(InValid), .InReady(InReady4),
        .OutAddr(OutAddr4), .OutCorr(OutCorr4), .OutUncorr(OutUncorr4), .OutRange(OutRange4),
        .OutValid(OutValid4), .OutReady(OutReady), .CntClear(CntClear),
        .CorrCnt(CorrCnt4), .UncorrCnt(UncorrCnt4)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   cnt_corr = 0;
    int   cnt_unc = 0;
    int   delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_parity(input logic [5:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5];
        p[2] = d[1] ^ d[2] ^ d[3];
        p[3] = d[4] ^ d[5];
        return p;
    endfunction

    function automatic logic [9:0] encode(input logic [5:0] a);
        return {ref_parity(a), a};
    endfunction

    // A word is correctable when exactly one bit flip turns it into a valid codeword.
    function automatic exp_t ref_decode(input logic [9:0] w);
        exp_t       r;
        logic [9:0] t;
        r.addr   = w[5:0];
        r.corr   = 1'b0;
        r.uncorr = 1'b0;
        if (ref_parity(w[5:0]) != w[9:6]) begin
            r.uncorr = 1'b1;
            for (int b = 0; b < 10; b++) begin
                t = w ^ (10'd1 << b);
                if (ref_parity(t[5:0]) == t[9:6]) begin
                    r.addr   = t[5:0];
                    r.corr   = 1'b1;
                    r.uncorr = 1'b0;
                end
            end
        end
        r.oor = (r.addr > 6'd39);
        return r;
    endfunction

    function automatic int sat(input int c, input int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    function automatic logic [9:0] rand_word();
        logic [9:0] w;
        w = encode(6'($urandom_range(0, 63)));
        case ($urandom_range(0, 3))
            0: ;
            1: w = w ^ (10'd1 << $urandom_range(0, 9));
            2: w = w ^ (10'd1 << $urandom_range(0, 9)) ^ (10'd1 << $urandom_range(0, 9));
            default: w = 10'($urandom_range(0, 1023));
        endcase
        return w;
    endfunction

    // One clock: drive inputs, check/advance the model at the falling edge, return after the rising edge.
    task automatic cycle(input logic v, input logic [9:0] w, input logic rdy, input logic clr,
                         input logic rst, output logic acc);
        exp_t e;
        logic hs;
        InValid  = v;
        InWord   = w;
        OutReady = rdy;
        CntClear = clr;
        Reset    = rst;
        @(negedge Clk);
        check("in_ready", InReady, (sb.size() < 2) || rdy);
        check("corr_cnt", CorrCnt, sat(cnt_corr, 16));
        check("uncorr_cnt", UncorrCnt, sat(cnt_unc, 16));
        check("corr_cnt4", CorrCnt4, sat(cnt_corr, 4));
        check("uncorr_cnt4", UncorrCnt4, sat(cnt_unc, 4));
        acc = v && InReady;
        hs  = 1'b0;
        e   = '0;
        if (rst) begin
            sb.delete();
            cnt_corr = 0;
            cnt_unc  = 0;
            acc      = 1'b0;
        end else begin
            if (OutValid && rdy) begin
                if (sb.size() == 0) begin
                    check("spurious_out", OutValid, 0);
                end else begin
                    e  = sb.pop_front();
                    hs = 1'b1;
                    check("out_addr", OutAddr, e.addr);
                    check("out_corr", OutCorr, e.corr);
                    check("out_uncorr", OutUncorr, e.uncorr);
                    check("out_range", OutRange, e.oor);
                    delivered++;
                end
            end
            if (clr) begin
                cnt_corr = 0;
                cnt_unc  = 0;
            end else if (hs) begin
                cnt_corr += int'(e.corr);
                cnt_unc  += int'(e.uncorr);
            end
            if (acc) sb.push_back(ref_decode(w));
        end
        @(posedge Clk);
        #1;
    endtask

    vec_t       tbl[12];
    logic       acc;
    int         lat;
    int         k;
    int         guard;
    int         tbl_corr;
    int         tbl_unc;
    int         base;
    logic [9:0] words[5];
    logic [5:0] first_addr;
    logic       have_first;

    initial begin
        tbl[0]  = '{10'h315, '{6'd21, 1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{10'h311, '{6'd21, 1'b1, 1'b0, 1'b0}};
        tbl[2]  = '{10'h395, '{6'd21, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{10'h11D, '{6'd29, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{10'h368, '{6'd40, 1'b0, 1'b0, 1'b1}};
        tbl[5]  = '{10'h2A7, '{6'd39, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{10'h000, '{6'd0,  1'b0, 1'b0, 1'b0}};
        tbl[7]  = '{10'h3FF, '{6'd63, 1'b0, 1'b1, 1'b1}};
        tbl[8]  = '{10'h348, '{6'd40, 1'b1, 1'b0, 1'b1}};
        tbl[9]  = '{10'h2A6, '{6'd39, 1'b1, 1'b0, 1'b0}};
        tbl[10] = '{10'h115, '{6'd21, 1'b1, 1'b0, 1'b0}};
        tbl[11] = '{10'h316, '{6'd18, 1'b1, 1'b0, 1'b0}};

        Reset = 1'b1; InValid = 1'b0; InWord = '0; OutReady = 1'b0; CntClear = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("rst_out_valid", OutValid, 0);
        check("rst_out_addr", OutAddr, 0);
        check("rst_flags", {OutCorr, OutUncorr, OutRange}, 0);
        check("rst_corr_cnt", CorrCnt, 0);
        check("rst_uncorr_cnt", UncorrCnt, 0);
        check("rst_in_ready", InReady, 1);

        // Directed table: each word alone, latency and decoded fields against constants.
        tbl_corr = 0;
        tbl_unc  = 0;
        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].word, 1'b1, 1'b0, 1'b0, acc);
            check("tbl_accept", acc, 1);
            lat = 1;
            while (!OutValid && lat < 8) begin
                cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
                lat++;
            end
            check("tbl_latency", lat, 2);
            check("tbl_addr", OutAddr, tbl[i].exp.addr);
            check("tbl_corr", OutCorr, tbl[i].exp.corr);
            check("tbl_uncorr", OutUncorr, tbl[i].exp.uncorr);
            check("tbl_range", OutRange, tbl[i].exp.oor);
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            tbl_corr += int'(tbl[i].exp.corr);
            tbl_unc  += int'(tbl[i].exp.uncorr);
        end
        check("tbl_corr_total", CorrCnt, tbl_corr);
        check("tbl_uncorr_total", UncorrCnt, tbl_unc);

        // Backpressure: five words offered with the output stalled.
        for (int i = 0; i < 5; i++) words[i] = encode(6'(i + 1));
        base = delivered;
        k = 0;
        have_first = 1'b0;
        first_addr = '0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, words[k], 1'b0, 1'b0, 1'b0, acc);
            if (acc) k++;
            if (OutValid) begin
                if (!have_first) begin
                    first_addr = OutAddr;
                    have_first = 1'b1;
                end else begin
                    check("stall_stable", OutAddr, first_addr);
                end
            end
        end
        check("stall_accepts", k, 2);
        check("stall_in_ready", InReady, 0);
        check("stall_out_valid", OutValid, 1);
        check("stall_first", first_addr, 1);
        guard = 0;
        while ((k < 5 || sb.size() > 0) && guard < 50) begin
            cycle(k < 5, words[k < 5 ? k : 0], 1'b1, 1'b0, 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        check("stall_all_sent", k, 5);
        check("stall_delivered", delivered - base, 5);

        // Saturation of the 4-bit counters.
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        k = 0;
        guard = 0;
        while ((k < 20 || sb.size() > 0) && guard < 100) begin
            cycle(k < 20, encode(6'(k)) ^ (10'd1 << (k % 10)), 1'b1, 1'b0, 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        check("sat_corr_cnt4", CorrCnt4, 15);
        check("sat_corr_cnt16", CorrCnt, 20);

        // Clear in the same cycle as a corrected-word handshake.
        cycle(1'b1, 10'h311, 1'b0, 1'b0, 1'b0, acc);
        guard = 0;
        while (!OutValid && guard < 8) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
            guard++;
        end
        check("clr_out_valid", OutValid, 1);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        check("clr_corr_cnt", CorrCnt, 0);
        check("clr_corr_cnt4", CorrCnt4, 0);

        // Reset with two words in flight.
        cycle(1'b1, encode(6'd7), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, encode(6'd8), 1'b0, 1'b0, 1'b0, acc);
        check("inflight_count", sb.size(), 2);
        check("inflight_out_valid", OutValid, 1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("rst_flight_out_valid", OutValid, 0);
        check("rst_flight_in_ready", InReady, 1);
        check("rst_flight_addr", OutAddr, 0);

        // Randomized traffic against the scoreboard.
        base = delivered;
        k = 0;
        guard = 0;
        while ((k < 10000 || sb.size() > 0) && guard < 60000) begin
            cycle((k < 10000) && ($urandom_range(0, 3) != 0), rand_word(),
                  (k >= 10000) || ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 499) == 0), 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        check("rand_sent", k, 10000);
        check("rand_delivered", delivered - base, 10000);
        check("rand_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
